inst_queue: RTL and testbench

- Decoupling FIFO between instruction fetch and the decode stage.
- Accepts up to two fetched instructions (word + PC) per cycle from the fetch/I-cache side.
- Presents one instruction per cycle to the decoder as a valid/inst/pc triple with a ready back-pressure handshake.
- Supports a single-cycle flush for branch-mispredict and exception redirect.

---
 rtl/inst_queue_if.sv | 35 +++
 rtl/inst_queue.sv | 112 +++++++++++
 tb/tb_inst_queue.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_if.sv
//------------------------------------------------------------------------------
// inst_queue_if
//   Fetch-to-decode instruction queue bus: fetch side, decode side and flush.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface inst_queue_if;
   logic        flush;
   logic        fetch_valid;
   logic [1:0]  fetch_num;
   logic [31:0] fetch_inst0;
   logic [31:0] fetch_pc0;
   logic [31:0] fetch_inst1;
   logic [31:0] fetch_pc1;
   logic        fetch_ready;
   logic        dec_valid;
   logic [31:0] dec_inst;
   logic [31:0] dec_pc;
   logic        dec_ready;

   modport master (
      output flush, fetch_valid, fetch_num, fetch_inst0, fetch_pc0,
             fetch_inst1, fetch_pc1, dec_ready,
      input  fetch_ready, dec_valid, dec_inst, dec_pc
   );

   modport slave (
      input  flush, fetch_valid, fetch_num, fetch_inst0, fetch_pc0,
             fetch_inst1, fetch_pc1, dec_ready,
      output fetch_ready, dec_valid, dec_inst, dec_pc
   );
endinterface

`default_nettype wire

// File: rtl/inst_queue.sv
//------------------------------------------------------------------------------
// inst_queue
//   Two-in / one-out instruction FIFO between fetch and decode with flush.
//   Optional same-cycle empty-queue bypass: INST_QUEUE_BYPASS_EN.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inst_queue #(
   parameter int DEPTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   inst_queue_if.slave   q
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] c_fill_limit = (PTR_W+1)'(DEPTH - 2);

   logic [63:0]      r_mem [DEPTH];
   logic [PTR_W:0]   r_rd_ptr;
   logic [PTR_W:0]   r_wr_ptr;

   logic [PTR_W:0]   w_count;
   logic [PTR_W-1:0] w_rd_idx;
   logic [PTR_W-1:0] w_wr_idx0;
   logic [PTR_W-1:0] w_wr_idx1;
   logic             w_empty;
   logic             w_fetch_ready;
   logic             w_wr_fire;
   logic             w_wr_en;
   logic             w_bypass;
   logic             w_consume;
   logic             w_rd_fire;
   logic [1:0]       w_store_n;
   logic [63:0]      w_head;
   logic [63:0]      w_slot0;

   assign w_count       = r_wr_ptr - r_rd_ptr;
   assign w_empty       = (w_count == '0);
   // Room is judged on the pre-read count so dec_ready never reaches fetch_ready.
   assign w_fetch_ready = (w_count <= c_fill_limit);
   assign w_wr_fire     = q.fetch_valid & w_fetch_ready & ~q.flush;
   assign w_wr_en       = w_wr_fire & ((q.fetch_num == 2'd1) | (q.fetch_num == 2'd2));
   assign w_rd_fire     = ~w_empty & q.dec_ready & ~q.flush;

`ifdef INST_QUEUE_BYPASS_EN
   assign w_bypass = w_empty & w_wr_en;
`else
   assign w_bypass = 1'b0;
`endif
   // inst0 handed straight to decode is never stored.
   assign w_consume = w_bypass & q.dec_ready;

   always_comb begin
      w_store_n = 2'd0;
      if (w_wr_en) begin
         w_store_n = (q.fetch_num == 2'd2) ? 2'd2 : 2'd1;
      end
      if (w_consume) begin
         w_store_n = w_store_n - 2'd1;
      end
   end

   assign w_slot0   = w_consume ? {q.fetch_inst1, q.fetch_pc1} : {q.fetch_inst0, q.fetch_pc0};
   assign w_rd_idx  = r_rd_ptr[PTR_W-1:0];
   assign w_wr_idx0 = r_wr_ptr[PTR_W-1:0];
   assign w_wr_idx1 = w_wr_idx0 + PTR_W'(1);
   assign w_head    = r_mem[w_rd_idx];

   assign q.fetch_ready = w_fetch_ready;
   assign q.dec_valid   = ~w_empty | w_bypass;

   always_comb begin
      q.dec_inst = 32'd0;
      q.dec_pc   = 32'd0;
      if (!w_empty) begin
         q.dec_inst = w_head[63:32];
         q.dec_pc   = w_head[31:0];
      end else if (w_bypass) begin
         q.dec_inst = q.fetch_inst0;
         q.dec_pc   = q.fetch_pc0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || q.flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (w_rd_fire) begin
            r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
         end
         r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(w_store_n);
      end
   end

   always_ff @(posedge clk) begin
      if (w_store_n != 2'd0) begin
         r_mem[w_wr_idx0] <= w_slot0;
      end
      if (w_store_n == 2'd2) begin
         r_mem[w_wr_idx1] <= {q.fetch_inst1, q.fetch_pc1};
      end
   end

   a_fetch_num_legal: assert property (@(posedge clk) disable iff (reset)
      !(w_wr_fire && (q.fetch_num == 2'd3)));

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
//------------------------------------------------------------------------------
// tb_inst_queue
//   Directed and random stimulus against a queue-based reference model.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_queue;

   localparam int DEPTH = 8;

   logic clk;
   logic reset;
   inst_queue_if bus ();

   inst_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .q     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] mq [$];
   bit          last_wr_fire;
   bit          track_order = 0;
   logic [31:0] exp_rd_pc;
   int          n_consumed;
   bit          saw_full;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_fetch(input bit v, input logic [1:0] num,
                            input logic [31:0] i0, input logic [31:0] p0,
                            input logic [31:0] i1, input logic [31:0] p1);
      bus.fetch_valid = v;
      bus.fetch_num   = num;
      bus.fetch_inst0 = i0;
      bus.fetch_pc0   = p0;
      bus.fetch_inst1 = i1;
      bus.fetch_pc1   = p1;
   endtask

   task automatic idle();
      set_fetch(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      bus.flush     = 1'b0;
      bus.dec_ready = 1'b0;
   endtask

   // Checks outputs against the model, then advances the model across one edge.
   task automatic cycle();
      int          n;
      bit          e_bp, e_ready, e_valid;
      logic [31:0] e_inst, e_pc;
      #1;
      n       = mq.size();
      e_ready = (DEPTH - n) >= 2;
      e_bp    = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
      e_bp = (n == 0) && bus.fetch_valid && e_ready && !bus.flush &&
             (bus.fetch_num == 2'd1 || bus.fetch_num == 2'd2);
`endif
      e_valid = (n != 0) || e_bp;
      e_inst  = 32'd0;
      e_pc    = 32'd0;
      if (n != 0) begin
         e_inst = mq[0][63:32];
         e_pc   = mq[0][31:0];
      end else if (e_bp) begin
         e_inst = bus.fetch_inst0;
         e_pc   = bus.fetch_pc0;
      end
      chk("fetch_ready", 32'(bus.fetch_ready), 32'(e_ready));
      chk("dec_valid",   32'(bus.dec_valid),   32'(e_valid));
      chk("dec_inst",    bus.dec_inst,         e_inst);
      chk("dec_pc",      bus.dec_pc,           e_pc);
      if (track_order && bus.dec_valid && bus.dec_ready && !bus.flush) begin
         chk("order_pc", bus.dec_pc, exp_rd_pc);
         exp_rd_pc = exp_rd_pc + 32'd4;
         n_consumed++;
      end
      if (!bus.fetch_ready) saw_full = 1'b1;
      @(posedge clk);
      last_wr_fire = 1'b0;
      if (reset || bus.flush) begin
         mq.delete();
      end else begin
         if (e_valid && bus.dec_ready && n != 0) void'(mq.pop_front());
         if (bus.fetch_valid && e_ready && (bus.fetch_num == 2'd1 || bus.fetch_num == 2'd2)) begin
            last_wr_fire = 1'b1;
            if (!(e_bp && bus.dec_ready)) mq.push_back({bus.fetch_inst0, bus.fetch_pc0});
            if (bus.fetch_num == 2'd2) mq.push_back({bus.fetch_inst1, bus.fetch_pc1});
         end
      end
      @(negedge clk);
   endtask

   task automatic do_flush();
      idle();
      bus.flush = 1'b1;
      cycle();
      bus.flush = 1'b0;
   endtask

   initial begin
      logic [31:0] pc;
      reset = 1'b1;
      idle();
      @(negedge clk);
      cycle();
      cycle();
      reset = 1'b0;

      // Reset state and first num=2 write.
      #1;
      chk("rst_dec_valid",   32'(bus.dec_valid),   32'd0);
      chk("rst_dec_inst",    bus.dec_inst,         32'd0);
      chk("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
      set_fetch(1'b1, 2'd2, 32'h24020001, 32'hBFC00000, 32'h24030002, 32'hBFC00004);
      cycle();
      idle();
      #1;
      chk("first_valid", 32'(bus.dec_valid), 32'd1);
      chk("first_inst",  bus.dec_inst,       32'h24020001);
      chk("first_pc",    bus.dec_pc,         32'hBFC00000);
      cycle();

      // Fill to seven with single writes, then one read.
      do_flush();
      for (int i = 0; i < 7; i++) begin
         set_fetch(1'b1, 2'd1, 32'hA000_0000 + 32'(i), 32'h1000 + 32'(4 * i), 32'd0, 32'd0);
         cycle();
      end
      set_fetch(1'b1, 2'd1, 32'hDEAD_BEEF, 32'h5555_0000, 32'd0, 32'd0);
      #1;
      chk("full7_ready", 32'(bus.fetch_ready), 32'd0);
      cycle();
      idle();
      bus.dec_ready = 1'b1;
      cycle();
      idle();
      #1;
      chk("after_read_ready", 32'(bus.fetch_ready), 32'd1);
      chk("after_read_pc",    bus.dec_pc,           32'h1004);
      for (int i = 0; i < 7; i++) begin
         bus.dec_ready = 1'b1;
         cycle();
      end

      // Continuous dual writes with a draining decoder.
      do_flush();
      pc          = 32'h2000;
      exp_rd_pc   = 32'h2000;
      n_consumed  = 0;
      saw_full    = 1'b0;
      track_order = 1'b1;
      for (int i = 0; i < 40; i++) begin
         set_fetch(1'b1, 2'd2, ~pc, pc, ~(pc + 32'd4), pc + 32'd4);
         bus.dec_ready = 1'b1;
         cycle();
         if (last_wr_fire) pc = pc + 32'd8;
      end
      track_order = 1'b0;
      chk("fill_seen", 32'(saw_full), 32'd1);
`ifdef INST_QUEUE_BYPASS_EN
      chk("consumed", 32'(n_consumed), 32'd40);
`else
      chk("consumed", 32'(n_consumed), 32'd39);
`endif

      // count=6: dual write plus read lands in slots 6/7.
      do_flush();
      for (int i = 0; i < 3; i++) begin
         set_fetch(1'b1, 2'd2, 32'hB000_0000 + 32'(2 * i), 32'h3000 + 32'(8 * i),
                   32'hB000_0001 + 32'(2 * i), 32'h3004 + 32'(8 * i));
         cycle();
      end
      set_fetch(1'b1, 2'd2, 32'hB000_0006, 32'h3018, 32'hB000_0007, 32'h301C);
      bus.dec_ready = 1'b1;
      #1;
      chk("six_ready", 32'(bus.fetch_ready), 32'd1);
      cycle();
      idle();
      #1;
      chk("seven_ready", 32'(bus.fetch_ready), 32'd0);
      chk("seven_head",  bus.dec_pc,           32'h3004);
      for (int i = 0; i < 8; i++) begin
         bus.dec_ready = 1'b1;
         cycle();
      end

      // count=5 then flush with a colliding write and read.
      do_flush();
      set_fetch(1'b1, 2'd2, 32'hC0, 32'h4000, 32'hC1, 32'h4004);
      cycle();
      set_fetch(1'b1, 2'd2, 32'hC2, 32'h4008, 32'hC3, 32'h400C);
      cycle();
      set_fetch(1'b1, 2'd1, 32'hC4, 32'h4010, 32'd0, 32'd0);
      cycle();
      set_fetch(1'b1, 2'd2, 32'hC5, 32'h4014, 32'hC6, 32'h4018);
      bus.flush     = 1'b1;
      bus.dec_ready = 1'b1;
      cycle();
      idle();
      #1;
      chk("flush_valid", 32'(bus.dec_valid),   32'd0);
      chk("flush_ready", 32'(bus.fetch_ready), 32'd1);
      set_fetch(1'b1, 2'd1, 32'h0000_0000, 32'h8000_0180, 32'd0, 32'd0);
      cycle();
      idle();
      #1;
      chk("redirect_pc",   bus.dec_pc,   32'h8000_0180);
      chk("redirect_inst", bus.dec_inst, 32'h0000_0000);
      cycle();

      // Empty-queue write with the decoder ready.
      do_flush();
      set_fetch(1'b1, 2'd2, 32'h3C1DBFC0, 32'hBFC00100, 32'h27BD0100, 32'hBFC00104);
      bus.dec_ready = 1'b1;
      #1;
`ifdef INST_QUEUE_BYPASS_EN
      chk("bypass_valid", 32'(bus.dec_valid), 32'd1);
      chk("bypass_inst",  bus.dec_inst,       32'h3C1DBFC0);
`else
      chk("bypass_valid", 32'(bus.dec_valid), 32'd0);
`endif
      cycle();
      idle();
      #1;
`ifdef INST_QUEUE_BYPASS_EN
      chk("bypass_next", bus.dec_inst, 32'h27BD0100);
`else
      chk("bypass_next", bus.dec_inst, 32'h3C1DBFC0);
`endif
      cycle();

      // Random traffic with occasional flush and reset.
      pc = 32'h9000_0000;
      for (int i = 0; i < 400; i++) begin
         set_fetch(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 2)),
                   $urandom, pc, $urandom, pc + 32'd4);
         pc = pc + 32'd8;
         bus.dec_ready = 1'($urandom_range(0, 2) != 0);
         bus.flush     = ($urandom_range(0, 29) == 0);
         reset         = ($urandom_range(0, 79) == 0);
         cycle();
      end
      reset = 1'b0;
      idle();
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
